// File: rtl/gpu_cmd_queue.sv
// Command queue between a host and a GPU engine.
// A small FIFO holds draw/clear commands and hands them to the GPU one at a
// time. Each command drives a registered parameter bundle plus a one-cycle
// strobe, then the queue waits for the GPU's busy flag to drop.
//
// Ports:
//   clk, reset         single rising-edge clock, async active-high reset
//   cmd_valid/ready    host offer/accept handshake
//   cmd_type           0 = draw, 1 = clear
//   cmd_flush          discard all unissued entries
//   cmd_*              command payload stored per entry
//   ctrl_*             registered payload of the command being executed
//   ctrl_draw/clear    one-cycle command strobes
//   ctrl_busy          GPU executing a command
//   queue_count        pending (unissued) entries
//   idle               nothing queued and nothing in flight
//   cmd_done           one-cycle completion pulse
module gpu_cmd_queue #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 4,
    localparam int WW = $clog2(FB_WIDTH) + 2,
    localparam int HW = $clog2(FB_HEIGHT) + 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_type,
    input  logic          cmd_flush,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [WW-1:0] cmd_width,
    input  logic [HW-1:0] cmd_height,
    input  logic [WW-1:0] cmd_x,
    input  logic [HW-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [WW-1:0] ctrl_width,
    output logic [HW-1:0] ctrl_height,
    output logic [WW-1:0] ctrl_x,
    output logic [HW-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,
    input  logic          ctrl_busy,
    output logic [CW-1:0] queue_count,
    output logic          idle,
    output logic          cmd_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic          is_clear;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [WW-1:0] width;
        logic [HW-1:0] height;
        logic [WW-1:0] x;
        logic [HW-1:0] y;
        logic [15:0]   clear_color;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    entry_t        issue_q, issue_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          done_q, done_d;
    logic          full;
    logic          push;
    logic          pop;

    always_comb begin
        wr_entry             = '0;
        wr_entry.is_clear    = cmd_type;
        wr_entry.address     = cmd_address;
        wr_entry.address_x   = cmd_address_x;
        wr_entry.address_y   = cmd_address_y;
        wr_entry.image_width = cmd_image_width;
        wr_entry.width       = cmd_width;
        wr_entry.height      = cmd_height;
        wr_entry.x           = cmd_x;
        wr_entry.y           = cmd_y;
        wr_entry.clear_color = cmd_clear_color;
    end

    // Room is judged on the registered count only; a same-cycle pop never
    // frees a slot for a push. Flush blocks pushes for its whole cycle.
    assign full      = (count_q == FULL_CNT);
    assign cmd_ready = !full && !cmd_flush;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0)
                       && !ctrl_busy && !cmd_flush;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        done_d   = 1'b0;
        issue_d  = issue_q;

        if (cmd_flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ISSUE;
                    issue_d = head;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!ctrl_busy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            issue_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            done_q   <= done_d;
            issue_q  <= issue_d;
        end
    end

    assign ctrl_address     = issue_q.address;
    assign ctrl_address_x   = issue_q.address_x;
    assign ctrl_address_y   = issue_q.address_y;
    assign ctrl_image_width = issue_q.image_width;
    assign ctrl_width       = issue_q.width;
    assign ctrl_height      = issue_q.height;
    assign ctrl_x           = issue_q.x;
    assign ctrl_y           = issue_q.y;
    assign ctrl_clear_color = issue_q.clear_color;

    assign ctrl_draw   = (state_q == S_ISSUE) && !issue_q.is_clear;
    assign ctrl_clear  = (state_q == S_ISSUE) && issue_q.is_clear;
    assign queue_count = count_q;
    assign idle        = (state_q == S_IDLE) && (count_q == '0);
    assign cmd_done    = done_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed testbench for gpu_cmd_queue.
// A small GPU model raises busy for busy_len cycles after each strobe.
module tb_gpu_cmd_queue;

    localparam int WW = 11;
    localparam int HW = 10;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_type = 1'b0;
    logic          cmd_flush = 1'b0;
    logic [31:0]   cmd_address = '0;
    logic [15:0]   cmd_address_x = '0;
    logic [15:0]   cmd_address_y = '0;
    logic [15:0]   cmd_image_width = '0;
    logic [WW-1:0] cmd_width = '0;
    logic [HW-1:0] cmd_height = '0;
    logic [WW-1:0] cmd_x = '0;
    logic [HW-1:0] cmd_y = '0;
    logic [15:0]   cmd_clear_color = '0;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x;
    logic [15:0]   ctrl_address_y;
    logic [15:0]   ctrl_image_width;
    logic [WW-1:0] ctrl_width;
    logic [HW-1:0] ctrl_height;
    logic [WW-1:0] ctrl_x;
    logic [HW-1:0] ctrl_y;
    logic [15:0]   ctrl_clear_color;
    logic          ctrl_draw;
    logic          ctrl_clear;
    logic          ctrl_busy;
    logic [CW-1:0] queue_count;
    logic          idle;
    logic          cmd_done;

    int checks;
    int errors;

    gpu_cmd_queue dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_type         (cmd_type),
        .cmd_flush        (cmd_flush),
        .cmd_address      (cmd_address),
        .cmd_address_x    (cmd_address_x),
        .cmd_address_y    (cmd_address_y),
        .cmd_image_width  (cmd_image_width),
        .cmd_width        (cmd_width),
        .cmd_height       (cmd_height),
        .cmd_x            (cmd_x),
        .cmd_y            (cmd_y),
        .cmd_clear_color  (cmd_clear_color),
        .ctrl_address     (ctrl_address),
        .ctrl_address_x   (ctrl_address_x),
        .ctrl_address_y   (ctrl_address_y),
        .ctrl_image_width (ctrl_image_width),
        .ctrl_width       (ctrl_width),
        .ctrl_height      (ctrl_height),
        .ctrl_x           (ctrl_x),
        .ctrl_y           (ctrl_y),
        .ctrl_clear_color (ctrl_clear_color),
        .ctrl_draw        (ctrl_draw),
        .ctrl_clear       (ctrl_clear),
        .ctrl_busy        (ctrl_busy),
        .queue_count      (queue_count),
        .idle             (idle),
        .cmd_done         (cmd_done)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int   busy_cnt;
    int   busy_len = 10;
    logic hold_busy = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (ctrl_draw || ctrl_clear) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign ctrl_busy = (busy_cnt != 0) || hold_busy;

    int          log_n;
    int          done_n;
    int          last_done_cyc;
    int          both_hi;
    logic [31:0] log_addr  [64];
    logic        log_clr   [64];
    logic [15:0] log_color [64];
    int          log_cyc   [64];

    always @(negedge clk) begin
        if (ctrl_draw || ctrl_clear) begin
            if (log_n < 64) begin
                log_addr[log_n]  = ctrl_address;
                log_clr[log_n]   = ctrl_clear;
                log_color[log_n] = ctrl_clear_color;
                log_cyc[log_n]   = cyc;
            end
            log_n = log_n + 1;
        end
        if (ctrl_draw && ctrl_clear) both_hi = both_hi + 1;
        if (cmd_done) begin
            done_n = done_n + 1;
            last_done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit typ, input logic [31:0] addr,
                        input logic [WW-1:0] w, input logic [HW-1:0] h,
                        input logic [WW-1:0] x, input logic [HW-1:0] y,
                        input logic [15:0] col, input bit fl,
                        output bit ok, output int pc);
        tick();
        cmd_type        = typ;
        cmd_address     = addr;
        cmd_address_x   = addr[15:0] + 16'h0011;
        cmd_address_y   = addr[15:0] + 16'h0022;
        cmd_image_width = addr[15:0] + 16'h0033;
        cmd_width       = w;
        cmd_height      = h;
        cmd_x           = x;
        cmd_y           = y;
        cmd_clear_color = col;
        cmd_flush       = fl;
        cmd_valid       = 1'b1;
        #1;
        ok = cmd_ready;
        pc = cyc + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL rst_idle: got %b want 1", idle);
        end
        checks++;
        if (queue_count !== 3'd0) begin
            errors++; $display("FAIL rst_count: got %0d want 0", queue_count);
        end
        checks++;
        if ({ctrl_draw, ctrl_clear, cmd_done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_strobes: got %b want 000",
                     {ctrl_draw, ctrl_clear, cmd_done});
        end
        checks++;
        if (ctrl_address !== 32'h0 || ctrl_clear_color !== 16'h0) begin
            errors++;
            $display("FAIL rst_params: got %h/%h want 0/0",
                     ctrl_address, ctrl_clear_color);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_draw();
        int n0, d0, pc, bad;
        bit ok, seen;
        busy_len = 50;
        n0 = log_n;
        d0 = done_n;
        push(1'b0, 32'h1000, 11'd16, 10'd8, 11'd10, 10'd20, 16'h0,
             1'b0, ok, pc);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL sd_accept: got %b want 1", ok);
        end
        bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (cyc >= pc + 1) begin
                if (ctrl_address !== 32'h1000 || ctrl_width !== 11'd16 ||
                    ctrl_height !== 10'd8 || ctrl_x !== 11'd10 ||
                    ctrl_y !== 10'd20 || ctrl_address_x !== 16'h1011 ||
                    ctrl_address_y !== 16'h1022 ||
                    ctrl_image_width !== 16'h1033) bad++;
            end
            if (done_n != d0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL sd_done_timeout: got none want 1");
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sd_param_stable: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (log_n - n0 != 1) begin
            errors++; $display("FAIL sd_strobe_cycles: got %0d want 1", log_n - n0);
        end
        checks++;
        if (log_cyc[n0] != pc + 1 || log_clr[n0] !== 1'b0) begin
            errors++;
            $display("FAIL sd_strobe_time: got cyc %0d clr %b want cyc %0d clr 0",
                     log_cyc[n0], log_clr[n0], pc + 1);
        end
        checks++;
        if (last_done_cyc != pc + 53) begin
            errors++;
            $display("FAIL sd_done_time: got %0d want %0d", last_done_cyc, pc + 53);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL sd_idle: got %b want 1", idle);
        end
        tick();
        checks++;
        if (cmd_done !== 1'b0 || done_n - d0 != 1) begin
            errors++;
            $display("FAIL sd_done_pulse: got %b/%0d want 0/1", cmd_done, done_n - d0);
        end
    endtask

    task automatic test_back_to_back();
        int n0, d0, pc1, pc2;
        bit ok1, ok2;
        busy_len = 20;
        n0 = log_n;
        d0 = done_n;
        push(1'b1, 32'h2000, 11'd0, 10'd0, 11'd0, 10'd0, 16'hF801,
             1'b0, ok1, pc1);
        push(1'b0, 32'h3000, 11'd32, 10'd4, 11'd1, 10'd2, 16'h0,
             1'b0, ok2, pc2);
        for (int i = 0; i < 300 && done_n < d0 + 2; i++) tick();
        checks++;
        if (done_n < d0 + 2) begin
            errors++; $display("FAIL b2b_timeout: got %0d dones want 2", done_n - d0);
        end
        checks++;
        if ({ok1, ok2} !== 2'b11 || log_n - n0 != 2) begin
            errors++;
            $display("FAIL b2b_count: got ok %b strobes %0d want 11/2",
                     {ok1, ok2}, log_n - n0);
        end
        checks++;
        if (log_clr[n0] !== 1'b1 || log_addr[n0] !== 32'h2000 ||
            log_cyc[n0] != pc1 + 1) begin
            errors++;
            $display("FAIL b2b_first: got clr %b addr %h cyc %0d want 1/2000/%0d",
                     log_clr[n0], log_addr[n0], log_cyc[n0], pc1 + 1);
        end
        checks++;
        if (log_color[n0] !== 16'hF801) begin
            errors++; $display("FAIL b2b_color: got %h want f801", log_color[n0]);
        end
        checks++;
        if (log_clr[n0+1] !== 1'b0 || log_addr[n0+1] !== 32'h3000) begin
            errors++;
            $display("FAIL b2b_order: got clr %b addr %h want 0/3000",
                     log_clr[n0+1], log_addr[n0+1]);
        end
        checks++;
        if (log_cyc[n0+1] != pc1 + 24) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want %0d", log_cyc[n0+1], pc1 + 24);
        end
    endtask

    task automatic test_full_queue();
        int n0, d0, pc;
        bit ok;
        logic [4:0] okv;
        hold_busy = 1'b1;
        busy_len = 3;
        n0 = log_n;
        d0 = done_n;
        okv = '0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'h100 + 32'(i), 11'd1, 10'd1, 11'd0, 10'd0, 16'h0,
                 1'b0, ok, pc);
            okv[i] = ok;
        end
        checks++;
        if (okv !== 5'b01111) begin
            errors++; $display("FAIL fq_accept: got %b want 01111", okv);
        end
        tick();
        checks++;
        if (queue_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fq_full: got count %0d ready %b want 4/0",
                     queue_count, cmd_ready);
        end
        hold_busy = 1'b0;
        for (int i = 0; i < 300 && done_n < d0 + 4; i++) tick();
        repeat (10) tick();
        checks++;
        if (log_n - n0 != 4 || done_n - d0 != 4) begin
            errors++;
            $display("FAIL fq_drain: got %0d strobes %0d dones want 4/4",
                     log_n - n0, done_n - d0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[n0+i] !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL fq_order%0d: got %h want %h",
                         i, log_addr[n0+i], 32'h100 + 32'(i));
            end
        end
        checks++;
        if (queue_count !== 3'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL fq_empty: got %0d/%b want 0/1", queue_count, idle);
        end
    endtask

    task automatic test_flush();
        int n0, d0, pc;
        bit ok;
        busy_len = 30;
        n0 = log_n;
        d0 = done_n;
        push(1'b0, 32'h500, 11'd1, 10'd1, 11'd0, 10'd0, 16'h0, 1'b0, ok, pc);
        push(1'b1, 32'h501, 11'd1, 10'd1, 11'd0, 10'd0, 16'h1, 1'b0, ok, pc);
        push(1'b0, 32'h502, 11'd1, 10'd1, 11'd0, 10'd0, 16'h0, 1'b0, ok, pc);
        push(1'b0, 32'h503, 11'd1, 10'd1, 11'd0, 10'd0, 16'h0, 1'b0, ok, pc);
        tick();
        checks++;
        if (queue_count !== 3'd3) begin
            errors++; $display("FAIL fl_pre_count: got %0d want 3", queue_count);
        end
        push(1'b0, 32'h5FF, 11'd1, 10'd1, 11'd0, 10'd0, 16'h0, 1'b1, ok, pc);
        checks++;
        if (ok !== 1'b0) begin
            errors++; $display("FAIL fl_ready: got %b want 0", ok);
        end
        checks++;
        if (queue_count !== 3'd0) begin
            errors++; $display("FAIL fl_count: got %0d want 0", queue_count);
        end
        for (int i = 0; i < 200 && done_n < d0 + 1; i++) tick();
        repeat (40) tick();
        checks++;
        if (done_n - d0 != 1) begin
            errors++; $display("FAIL fl_done: got %0d want 1", done_n - d0);
        end
        checks++;
        if (log_n - n0 != 1 || log_addr[n0] !== 32'h500) begin
            errors++;
            $display("FAIL fl_strobes: got %0d first %h want 1/500",
                     log_n - n0, log_addr[n0]);
        end
        checks++;
        if (queue_count !== 3'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL fl_idle: got %0d/%b want 0/1", queue_count, idle);
        end
    endtask

    task automatic test_busy_at_idle();
        int n0, d0, pc, rc;
        bit ok;
        hold_busy = 1'b1;
        busy_len = 5;
        n0 = log_n;
        d0 = done_n;
        push(1'b0, 32'h900, 11'd2, 10'd2, 11'd0, 10'd0, 16'h0, 1'b0, ok, pc);
        repeat (10) tick();
        checks++;
        if (log_n != n0 || queue_count !== 3'd1) begin
            errors++;
            $display("FAIL bi_hold: got %0d strobes count %0d want 0/1",
                     log_n - n0, queue_count);
        end
        tick();
        hold_busy = 1'b0;
        rc = cyc;
        for (int i = 0; i < 100 && done_n < d0 + 1; i++) tick();
        checks++;
        if (log_n - n0 != 1 || log_cyc[n0] != rc + 1) begin
            errors++;
            $display("FAIL bi_release: got %0d strobes at %0d want 1 at %0d",
                     log_n - n0, log_cyc[n0], rc + 1);
        end
    endtask

    task automatic test_reset_wait_done();
        int n0, d0, pc;
        bit ok;
        busy_len = 40;
        push(1'b0, 32'h700, 11'd3, 10'd3, 11'd5, 10'd6, 16'h0, 1'b0, ok, pc);
        push(1'b0, 32'h701, 11'd3, 10'd3, 11'd5, 10'd6, 16'h0, 1'b0, ok, pc);
        repeat (10) tick();
        checks++;
        if (queue_count !== 3'd1 || ctrl_address !== 32'h700) begin
            errors++;
            $display("FAIL rw_pre: got %0d/%h want 1/700", queue_count, ctrl_address);
        end
        n0 = log_n;
        d0 = done_n;
        tick();
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl_address !== 32'h0 || ctrl_width !== 11'd0 ||
            ctrl_x !== 11'd0 || ctrl_y !== 10'd0) begin
            errors++;
            $display("FAIL rw_params: got %h %0d %0d %0d want zeros",
                     ctrl_address, ctrl_width, ctrl_x, ctrl_y);
        end
        checks++;
        if ({ctrl_draw, ctrl_clear, cmd_done} !== 3'b000 ||
            queue_count !== 3'd0 || cmd_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rw_status: got %b cnt %0d rdy %b idle %b want 000/0/1/1",
                     {ctrl_draw, ctrl_clear, cmd_done}, queue_count,
                     cmd_ready, idle);
        end
        @(posedge clk);
        tick();
        reset = 1'b0;
        repeat (60) tick();
        checks++;
        if (done_n != d0 || log_n != n0) begin
            errors++;
            $display("FAIL rw_quiet: got %0d dones %0d strobes want 0/0",
                     done_n - d0, log_n - n0);
        end
        test_single_draw();
    endtask

    initial begin
        test_reset();
        test_single_draw();
        test_back_to_back();
        test_full_queue();
        test_flush();
        test_busy_at_idle();
        test_reset_wait_done();
        checks++;
        if (both_hi != 0) begin
            errors++; $display("FAIL strobe_overlap: got %0d want 0", both_hi);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 Parameters SHALL be: FB_WIDTH, default 400, framebuffer width; FB_HEIGHT, default 240, framebuffer height; DEPTH, default 4, queue entries (power of two, at least 2).
REQ-002 Widths SHALL be: WW = $clog2(FB_WIDTH)+2 and HW = $clog2(FB_HEIGHT)+2.
REQ-003 Clock and reset SHALL be: clk  in  1  single clock, all logic on rising edge; reset  in  1  asynchronous, active-high.
REQ-004 Host enqueue ports SHALL be: cmd_valid in 1 offer; cmd_ready out 1 accept; cmd_type in 1 (0 = draw, 1 = clear); cmd_flush in 1 discard pending entries.
REQ-005 Host payload ports SHALL be: cmd_address in 32; cmd_address_x in 16; cmd_address_y in 16; cmd_image_width in 16; cmd_width in WW; cmd_height in HW; cmd_x in WW; cmd_y in HW; cmd_clear_color in 16.
REQ-006 GPU-side ports SHALL be out, with the same widths as the cmd_* payload: ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color; plus ctrl_draw out 1, ctrl_clear out 1, and ctrl_busy in 1.
REQ-007 Status ports SHALL be: queue_count out $clog2(DEPTH+1) pending entries; idle out 1 (queue empty and no command in flight); cmd_done out 1 one-cycle completion pulse.

Function
REQ-008 A command SHALL be accepted on a rising clk edge where cmd_valid && cmd_ready; the full payload plus cmd_type is stored as one FIFO entry.
REQ-009 cmd_ready SHALL equal !full, where full means queue_count == DEPTH; a pop in the same cycle does not make room for a push while full.
REQ-010 The FSM SHALL have three states: IDLE, ISSUE, WAIT_DONE.
REQ-011 IDLE -> ISSUE SHALL occur when the FIFO is non-empty and ctrl_busy == 0. On that edge the head entry is popped and its payload is registered onto the ctrl_* parameter outputs.
REQ-012 In ISSUE (exactly one cycle), ctrl_draw SHALL be 1 if the type is draw, otherwise ctrl_clear SHALL be 1; the next state is always WAIT_DONE.
REQ-013 In WAIT_DONE, ctrl_draw and ctrl_clear SHALL be 0. The block SHALL leave WAIT_DONE on the first cycle where ctrl_busy == 0, pulse cmd_done for 1 cycle on that exit, and return to IDLE.
REQ-014 IDLE SHALL hold at least one cycle after WAIT_DONE, so each strobe is preceded by at least 2 low cycles; the GPU detects the rising edge of the strobe.
REQ-015 The ctrl_* parameter outputs SHALL be registered and SHALL stay stable from ISSUE until the next ISSUE; the GPU samples them continuously during execution.
REQ-016 At most one strobe SHALL be high in any cycle, and a strobe SHALL never be asserted while ctrl_busy was 1 in the preceding IDLE cycle.
REQ-017 Command latency SHALL be: a push into an empty queue with the GPU idle produces a strobe 2 cycles after the accepting edge (edge N push, edge N+1 ISSUE entered, strobe high during cycle N+1).
REQ-018 On cmd_flush == 1, all unissued FIFO entries SHALL be discarded and queue_count set to 0 on the next edge. A command in ISSUE or WAIT_DONE completes normally.
REQ-019 cmd_flush SHALL have priority over a simultaneous push; that push is dropped, and cmd_ready SHALL be 0 while cmd_flush is 1.
REQ-020 Simultaneous push and pop when not full SHALL leave queue_count unchanged.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH without loss or reordering.
REQ-022 idle SHALL be 1 iff state == IDLE and queue_count == 0.

Reset
REQ-023 Assertion of reset SHALL immediately force: state IDLE; FIFO empty; queue_count 0; ctrl_draw, ctrl_clear and cmd_done 0; all ctrl_* parameter outputs 0; cmd_ready 1; idle 1.
REQ-024 Reset mid-operation (ISSUE or WAIT_DONE) SHALL abandon the in-flight command with no cmd_done pulse. After release, no strobe is issued until a new command is accepted.

Verification
REQ-025 Single draw: push draw (address 0x1000, width 16, height 8, x 10, y 20), GPU model holds busy 50 cycles -> ctrl_draw high exactly 1 cycle 2 cycles after push; params stable throughout; cmd_done 1 cycle after busy drops; idle returns to 1.
REQ-026 Back-to-back: push clear (color 0xF801) then draw while busy -> draw strobe only after busy falls and at least 1 IDLE cycle; ctrl_clear_color = 0xF801 during the clear; order preserved.
REQ-027 Full queue: GPU held busy, push DEPTH+1 commands -> cmd_ready 0 after DEPTH, queue_count = DEPTH, extra command not accepted; draining issues all DEPTH in order with wraparound.
REQ-028 Flush: 3 queued, 1 in flight, assert cmd_flush with cmd_valid 1 -> queue_count 0, in-flight command completes with cmd_done, no further strobes, pushed command dropped.
REQ-029 Reset in WAIT_DONE: assert reset asynchronously mid-cycle -> strobes and parameter outputs 0 immediately, queue_count 0, no cmd_done; a subsequent push behaves as in REQ-025.
REQ-030 Busy at idle: ctrl_busy held 1 externally with queue non-empty -> no strobe until busy falls, then strobe on the next cycle.
